reg_bank_uart_tx: RTL
=====================

// Module: reg_bank_uart_tx
// PURPOSE
//  UART transmitter that reads back the GPS generator configuration held by the register bank.
//  On a one-cycle trigger it snapshots all configuration fields and sends a fixed 7-byte frame, 8N1, LSB first.
//  It sits beside reg_bank_reduced at the top level and drives a spare output pin.
//  The host can then confirm a configuration written over rx_in.
// PARAMETERS
//  CLKS_PER_BIT  142  clock cycles per UART bit; must be >= 2; same value as the receiver
// PORTS
//  clk_in          input   1   system clock; single clock domain
//  rst_in_n        input   1   reset, asynchronous, active-low
//  trigger_in      input   1   readback request, sampled every clk_in rising edge
//  enable_in       input   1   general enable field
//  n_sat_in        input   5   satellite number field
//  noise_off_in    input   1   noise disable field
//  signal_off_in   input   1   signal disable field
//  ca_phase_in     input  16   C/A code phase field
//  doppler_in      input   8   doppler field
//  snr_in          input   8   SNR field
//  tx_out          output  1   UART serial line; idle high
//  busy_out        output  1   high while a frame is being sent
//  done_out        output  1   one-cycle pulse when the last stop bit completes
// BEHAVIOUR
//  Reset (async assert, sync release)
//   - tx_out=1, busy_out=0, done_out=0; FSM goes to IDLE; all counters cleared.
//   - Reset asserted mid-frame aborts the frame at once and leaves the line high.
//  Frame format, in send order
//   - B0=8'hA5 (header)
//   - B1={enable,noise_off,signal_off,n_sat[4:0]}
//   - B2=ca_phase[15:8], B3=ca_phase[7:0]
//   - B4=doppler, B5=snr
//   - B6=B1^B2^B3^B4^B5 (XOR checksum; header not included)
//  Trigger accept
//   - trigger_in=1 at edge k while IDLE: all fields are captured into snapshot regs at edge k.
//   - Inputs changing after edge k do not affect the frame.
//   - From edge k+1: tx_out=0 (start bit) and busy_out=1.
//  Bit timing
//   - Each bit (start, d0..d7, stop=1) holds exactly CLKS_PER_BIT cycles.
//   - Bytes follow back-to-back with no idle gap.
//   - Whole frame = 70*CLKS_PER_BIT cycles.
//  Frame end
//   - At the edge that ends B6's stop bit: busy_out->0, done_out=1 for one cycle, FSM -> IDLE.
//   - tx_out stays 1.
//  Busy and retrigger
//   - trigger_in while busy_out=1 is ignored. It is not queued and the snapshot is not updated.
//   - trigger_in is accepted again on the same edge that done_out is high. That gives zero idle gap between frames.
//   - A held-high trigger_in therefore sends frames continuously.
//  FSM
//   - IDLE -> START -> DATA(8 bits) -> STOP -> (byte_idx<6 ? START : IDLE).
//   - byte_idx counts 0..6 and is not allowed to wrap.
//   - Bit-period counter counts 0..CLKS_PER_BIT-1 and sized with $clog2(CLKS_PER_BIT).
//  tx_out is driven from a register (glitch-free) and is never combinational.
// STRUCTURE
//  Shared package gps_gen_pkg holds:
//   - RB_HDR=8'hA5, RB_FRAME_BYTES=7
//   - the B1 field-packing order, shared with reg_bank_reduced
//  Sub-module uart_tx_byte(CLKS_PER_BIT): valid/ready byte serializer
//   - accepts a byte when valid&&ready
//   - ready is high in the cycle its stop bit ends
//  Top FSM: snapshot, byte sequencing, checksum accumulation, busy/done.
// TESTING  (CLKS_PER_BIT=4 unless noted; bench UART monitor samples mid-bit)
//  1 Reset only -> tx_out=1, busy_out=0, done_out=0 for 100 cycles.
//  2 enable=1, noise_off=0, signal_off=1, n_sat=3, ca_phase=16'h1234, doppler=8'h7F, snr=8'h40; pulse trigger
//    -> bytes A5 A3 12 34 7F 40 BA.
//    -> start bit at edge k+1; done_out at edge k+1+280; busy_out high exactly 280 cycles.
//  3 Change all inputs and pulse trigger 10 cycles into the frame
//    -> frame identical to test 2; no second frame follows.
//  4 trigger_in held high for 3 frames
//    -> 3 contiguous frames with no idle gap; done_out pulses every 280 cycles.
//  5 Assert rst_in_n low in the middle of B3
//    -> tx_out=1 and busy_out=0 in the same cycle.
//    -> after release, a new trigger sends a complete, correct frame.
//  6 CLKS_PER_BIT=142, all fields 0 -> bytes A5 00 00 00 00 00 00; each bit lasts 142 cycles.

Source files
------------

// File: rtl/gps_gen_pkg.sv
// rtl/gps_gen_pkg.sv - shared GPS generator register-bank constants, config struct and B1 packing
package gps_gen_pkg;

    localparam logic [7:0] RB_HDR         = 8'hA5;
    localparam int         RB_FRAME_BYTES = 7;

    typedef struct packed {
        logic        enable;
        logic        noise_off;
        logic        signal_off;
        logic [4:0]  n_sat;
        logic [15:0] ca_phase;
        logic [7:0]  doppler;
        logic [7:0]  snr;
    } rb_cfg_t;

    // Same bit order reg_bank_reduced uses when it unpacks this byte from rx_in.
    function automatic logic [7:0] rb_pack_b1(input logic       enable,
                                              input logic       noise_off,
                                              input logic       signal_off,
                                              input logic [4:0] n_sat);
        return {enable, noise_off, signal_off, n_sat};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 LSB-first byte serializer with valid/ready byte input
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 142
) (
    input  logic       clk_in,
    input  logic       rst_in_n,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    output logic       tx_out
);

    localparam int             CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  BIT_LAST = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tx_q;
    logic          bit_end;
    logic          accept;

    assign bit_end  = (bit_cnt == BIT_LAST);
    // Ready in the last cycle of the stop bit lets the next byte's start bit
    // follow with no idle gap.
    assign s_tready = (state == ST_IDLE) || ((state == ST_STOP) && bit_end);
    assign accept   = s_tvalid && s_tready;
    assign tx_out   = tx_q;

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx_q    <= 1'b1;
        end else if (accept) begin
            state   <= ST_START;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= s_tdata;
            tx_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx_q    <= 1'b1;
                    bit_cnt <= '0;
                end
                ST_START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        state   <= ST_DATA;
                        tx_q    <= shreg[0];
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                            tx_q  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx_q    <= shreg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/reg_bank_uart_tx.sv
// rtl/reg_bank_uart_tx.sv - snapshots GPS generator config on trigger and sends a 7-byte UART readback frame
module reg_bank_uart_tx
    import gps_gen_pkg::*;
#(
    parameter int CLKS_PER_BIT = 142
) (
    input  logic        clk_in,
    input  logic        rst_in_n,
    input  logic        trigger_in,
    input  logic        enable_in,
    input  logic [4:0]  n_sat_in,
    input  logic        noise_off_in,
    input  logic        signal_off_in,
    input  logic [15:0] ca_phase_in,
    input  logic [7:0]  doppler_in,
    input  logic [7:0]  snr_in,
    output logic        tx_out,
    output logic        busy_out,
    output logic        done_out
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SEND  = 1'b1;
    localparam logic [2:0] LAST_IDX = 3'(RB_FRAME_BYTES - 1);

    logic [0:0] state;
    rb_cfg_t    cfg_in;
    rb_cfg_t    snap;
    logic [2:0] byte_idx;
    logic       all_sent;
    logic [7:0] csum;
    logic       busy_q;
    logic       done_q;

    logic       s_tvalid;
    logic       s_tready;
    logic [7:0] s_tdata;
    logic [7:0] cur_byte;
    logic       frame_end;
    logic       restart;
    logic       accept;

    assign cfg_in = {enable_in, noise_off_in, signal_off_in, n_sat_in,
                     ca_phase_in, doppler_in, snr_in};

    always_comb begin
        cur_byte = csum;
        case (byte_idx)
            3'd0:    cur_byte = RB_HDR;
            3'd1:    cur_byte = rb_pack_b1(snap.enable, snap.noise_off, snap.signal_off, snap.n_sat);
            3'd2:    cur_byte = snap.ca_phase[15:8];
            3'd3:    cur_byte = snap.ca_phase[7:0];
            3'd4:    cur_byte = snap.doppler;
            3'd5:    cur_byte = snap.snr;
            default: cur_byte = csum;
        endcase
    end

    // frame_end is the cycle whose closing edge ends B6's stop bit. A trigger
    // seen then starts the next frame on that same edge; the header is a
    // constant, so it can be handed over before the new snapshot is visible.
    assign frame_end = (state == ST_SEND) && all_sent && s_tready;
    assign restart   = frame_end && trigger_in;
    assign s_tvalid  = ((state == ST_SEND) && !all_sent) || restart;
    assign s_tdata   = restart ? RB_HDR : cur_byte;
    assign accept    = s_tvalid && s_tready;

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state    <= ST_IDLE;
            snap     <= '0;
            byte_idx <= '0;
            all_sent <= 1'b0;
            csum     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= frame_end;
            if (state == ST_IDLE) begin
                if (trigger_in) begin
                    snap     <= cfg_in;
                    byte_idx <= '0;
                    all_sent <= 1'b0;
                    state    <= ST_SEND;
                end
            end else if (frame_end) begin
                if (trigger_in) begin
                    snap     <= cfg_in;
                    byte_idx <= 3'd1;
                    all_sent <= 1'b0;
                    csum     <= '0;
                end else begin
                    state    <= ST_IDLE;
                    busy_q   <= 1'b0;
                    byte_idx <= '0;
                end
            end else if (accept) begin
                busy_q <= 1'b1;
                // Header is excluded from the checksum; B6 itself is the result.
                if (byte_idx == 3'd0) begin
                    csum <= '0;
                end else if (byte_idx != LAST_IDX) begin
                    csum <= csum ^ s_tdata;
                end
                if (byte_idx == LAST_IDX) begin
                    all_sent <= 1'b1;
                end else begin
                    byte_idx <= byte_idx + 3'd1;
                end
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_ser (
        .clk_in   (clk_in),
        .rst_in_n (rst_in_n),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .tx_out   (tx_out)
    );

    assign busy_out = busy_q;
    assign done_out = done_q;

endmodule
